// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: BCD HH:MM:SS gameplay timer with best-completion-time tracking
// for the on-screen time overlay (upper row current time, lower row best time).
module game_timer_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause_sw,
    input  logic        finish,
    input  logic        abort,
    output logic [23:0] cur_time,
    output logic [23:0] best_time,
    output logic        best_valid,
    output logic        running,
    output logic        new_best,
    output logic        tick_1Hz
);

    localparam int unsigned TIME_W   = 24;
    localparam logic [TIME_W-1:0] TIME_MAX = 24'h995959;
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [TIME_W-1:0]   cur_time_q, cur_time_d;
    logic [TIME_W-1:0]   best_time_q, best_time_d;
    logic                best_valid_q, best_valid_d;
    logic                running_q, running_d;
    logic                new_best_q, new_best_d;
    logic                tick_q, tick_d;

    // One-second BCD increment with sec/min wrapping at 59 and carry into hours.
    function automatic logic [TIME_W-1:0] bcd_inc(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] r;
        r = t;
        if (r[3:0] != 4'd9) begin
            r[3:0] = r[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (r[7:4] != 4'd5) begin
                r[7:4] = r[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (r[11:8] != 4'd9) begin
                    r[11:8] = r[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (r[15:12] != 4'd5) begin
                        r[15:12] = r[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (r[19:16] != 4'd9) begin
                            r[19:16] = r[19:16] + 4'd1;
                        end else begin
                            r[19:16] = 4'd0;
                            r[23:20] = r[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            cur_time_q   <= '0;
            best_time_q  <= '0;
            best_valid_q <= 1'b0;
            running_q    <= 1'b0;
            new_best_q   <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cur_time_q   <= cur_time_d;
            best_time_q  <= best_time_d;
            best_valid_q <= best_valid_d;
            running_q    <= running_d;
            new_best_q   <= new_best_d;
            tick_q       <= tick_d;
        end
    end

    // Next-state logic; priority abort > finish > start > pause/tick.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cur_time_d   = cur_time_q;
        best_time_d  = best_time_q;
        best_valid_d = best_valid_q;
        new_best_d   = 1'b0;
        tick_d       = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            cur_time_d = '0;
            div_d      = '0;
        end else if (finish && (state_q == RUN || state_q == PAUSED)) begin
            // A tick due on this edge is dropped; compare uses the held time.
            state_d = DONE;
            if (!best_valid_q || (cur_time_q < best_time_q)) begin
                best_time_d  = cur_time_q;
                best_valid_d = 1'b1;
                new_best_d   = 1'b1;
            end
        end else if (start) begin
            state_d    = RUN;
            cur_time_d = '0;
            div_d      = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (pause_sw) begin
                        state_d = PAUSED;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (cur_time_q != TIME_MAX) begin
                            cur_time_d = bcd_inc(cur_time_q);
                            tick_d     = 1'b1;
                        end
                    end else begin
                        div_d = div_q + CNT_W'(1);
                    end
                end
                PAUSED: begin
                    if (!pause_sw) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    assign cur_time   = cur_time_q;
    assign best_time  = best_time_q;
    assign best_valid = best_valid_q;
    assign running    = running_q;
    assign new_best   = new_best_q;
    assign tick_1Hz   = tick_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed scenarios plus random stimulus, all
// checked every cycle against a seconds-based reference model.
module tb_game_timer_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 3;
    localparam int SEC_MAX = 99 * 3600 + 59 * 60 + 59;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic        clk = 1'b0;
    logic        reset, start, pause_sw, finish, abort;
    logic [23:0] cur_time, best_time;
    logic        best_valid, running, new_best, tick_1Hz;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time held as plain seconds, divider as edge count.
    int m_st, m_sec, m_div, m_best, m_best_ok, m_nb, m_tk;

    game_timer_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause_sw  (pause_sw),
        .finish    (finish),
        .abort     (abort),
        .cur_time  (cur_time),
        .best_time (best_time),
        .best_valid(best_valid),
        .running   (running),
        .new_best  (new_best),
        .tick_1Hz  (tick_1Hz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_sec = 0; m_div = 0; m_best = 0; m_best_ok = 0; m_nb = 0; m_tk = 0;
    endtask

    task automatic model_step();
        m_nb = 0;
        m_tk = 0;
        if (reset) begin
            model_reset();
        end else if (abort) begin
            m_st = M_IDLE; m_sec = 0; m_div = 0;
        end else if (finish && (m_st == M_RUN || m_st == M_PAUSED)) begin
            m_st = M_DONE;
            if (!m_best_ok || m_sec < m_best) begin
                m_best = m_sec; m_best_ok = 1; m_nb = 1;
            end
        end else if (start) begin
            m_st = M_RUN; m_sec = 0; m_div = 0;
        end else if (m_st == M_RUN) begin
            if (pause_sw) begin
                m_st = M_PAUSED;
            end else begin
                m_div++;
                if (m_div == TICK_DIV) begin
                    m_div = 0;
                    if (m_sec < SEC_MAX) begin
                        m_sec++; m_tk = 1;
                    end
                end
            end
        end else if (m_st == M_PAUSED && !pause_sw) begin
            m_st = M_RUN;
        end
    endtask

    task automatic compare_all();
        check_eq("cur_time",   32'(cur_time),   32'(to_bcd(m_sec)));
        check_eq("best_time",  32'(best_time),  32'(to_bcd(m_best)));
        check_eq("best_valid", 32'(best_valid), 32'(m_best_ok));
        check_eq("running",    32'(running),    32'(m_st == M_RUN));
        check_eq("new_best",   32'(new_best),   32'(m_nb));
        check_eq("tick_1Hz",   32'(tick_1Hz),   32'(m_tk));
    endtask

    // One clock: advance model on the edge, sample outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; step(); finish = 1'b0;
    endtask

    task automatic wait_sec(input int target, input int budget);
        int k;
        k = 0;
        while (m_sec != target && k < budget) begin
            step();
            k++;
        end
        if (m_sec != target) check_eq("wait_timeout", 32'(m_sec), 32'(target));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause_sw = 1'b0; finish = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) step();
        check_eq("rst_cur", 32'(cur_time), 32'h0);
        check_eq("rst_run", 32'(running), 32'h0);
        reset = 1'b0;

        // First increment lands TICK_DIV edges after start; tick pulses once.
        pulse_start();
        repeat (3) step();
        check_eq("t2_pre", 32'(cur_time), 32'h000000);
        step();
        check_eq("t2_first", 32'(cur_time), 32'h000001);
        check_eq("t2_tick", 32'(tick_1Hz), 32'h1);
        step();
        check_eq("t2_tick_off", 32'(tick_1Hz), 32'h0);

        // Pause holds the divider; resume costs one edge.
        pulse_start();
        repeat (2) step();
        pause_sw = 1'b1;
        repeat (10) begin
            step();
            check_eq("t4_paused_run", 32'(running), 32'h0);
        end
        pause_sw = 1'b0;
        step();
        check_eq("t4_resume_run", 32'(running), 32'h1);
        step();
        check_eq("t4_hold", 32'(cur_time), 32'h000000);
        step();
        check_eq("t4_inc", 32'(cur_time), 32'h000001);

        // Best-time tracking: 5 sets, 7 ignored, 3 improves.
        pulse_start();
        wait_sec(5, 64);
        pulse_finish();
        check_eq("t5_best5", 32'(best_time), 32'h000005);
        check_eq("t5_valid", 32'(best_valid), 32'h1);
        check_eq("t5_nb5", 32'(new_best), 32'h1);
        step();
        check_eq("t5_nb_off", 32'(new_best), 32'h0);
        pulse_start();
        wait_sec(7, 64);
        pulse_finish();
        check_eq("t5_best_keep", 32'(best_time), 32'h000005);
        check_eq("t5_nb7", 32'(new_best), 32'h0);
        pulse_start();
        wait_sec(3, 64);
        pulse_finish();
        check_eq("t5_best3", 32'(best_time), 32'h000003);
        check_eq("t5_nb3", 32'(new_best), 32'h1);

        // Finish on a due tick: tick dropped, compare on pre-edge time.
        pulse_start();
        wait_sec(2, 64);
        repeat (3) step();
        pulse_finish();
        check_eq("t6_cur_frozen", 32'(cur_time), 32'h000002);
        check_eq("t6_tick_drop", 32'(tick_1Hz), 32'h0);
        check_eq("t6_best2", 32'(best_time), 32'h000002);
        repeat (6) step();
        check_eq("t6_done_hold", 32'(cur_time), 32'h000002);
        // finish and start together: finish wins.
        pulse_start();
        repeat (2) step();
        finish = 1'b1; start = 1'b1; step(); finish = 1'b0; start = 1'b0;
        check_eq("t6_fin_wins", 32'(running), 32'h0);
        abort = 1'b1; step(); abort = 1'b0;
        check_eq("t6_abort_cur", 32'(cur_time), 32'h000000);
        check_eq("t6_abort_bv", 32'(best_valid), 32'h1);

        // BCD carries and saturation.
        pulse_start();
        wait_sec(3599, 20000);
        check_eq("t3_005959", 32'(cur_time), 32'h005959);
        wait_sec(3600, 8);
        check_eq("t3_010000", 32'(cur_time), 32'h010000);
        pause_sw = 1'b1;
        step();
        force dut.cur_time_q = 24'h095959;
        m_sec = 9 * 3600 + 59 * 60 + 59;
        step();
        release dut.cur_time_q;
        check_eq("t3_preload9", 32'(cur_time), 32'h095959);
        pause_sw = 1'b0;
        wait_sec(10 * 3600, 16);
        check_eq("t3_100000", 32'(cur_time), 32'h100000);
        pause_sw = 1'b1;
        step();
        force dut.cur_time_q = 24'h995959;
        m_sec = SEC_MAX;
        step();
        release dut.cur_time_q;
        pause_sw = 1'b0;
        repeat (12) begin
            step();
            check_eq("t3_sat_tick", 32'(tick_1Hz), 32'h0);
        end
        check_eq("t3_sat_hold", 32'(cur_time), 32'h995959);

        // Asynchronous reset mid-run at 00:00:07.
        pulse_start();
        wait_sec(7, 64);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_eq("t1_cur", 32'(cur_time), 32'h000000);
        check_eq("t1_best", 32'(best_time), 32'h000000);
        check_eq("t1_bv", 32'(best_valid), 32'h0);
        check_eq("t1_run", 32'(running), 32'h0);
        compare_all();
        step();
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            start  = ($urandom_range(0, 39) == 0);
            finish = ($urandom_range(0, 29) == 0);
            abort  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) pause_sw = ~pause_sw;
            step();
        end
        start = 1'b0; finish = 1'b0; abort = 1'b0; pause_sw = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
